// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the back half of the 24-bit
// pipeline (memory and writeback stages).
//   DATA_W / REG_AW : datapath and register-address widths
//   PC_REG          : register index aliased to the PC, never forwarded
//   fwd_sel_t       : forwarding select encoding seen by the execute stage
//   m_state_t       : memory-stage handshake states
//   stage_t         : contents of a pipeline register between stages
package pipe_pkg;

  localparam int DATA_W = 24;
  localparam int REG_AW = 4;
  localparam logic [REG_AW-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } m_state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_AW-1:0] wa3;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              pc_src;
  } stage_t;

  // A bubble carries no valid bit and no control bits.
  localparam stage_t STAGE_BUBBLE = '0;

  // True when a writer to 'wa' produces the register 'ra' is reading.
  // The PC alias is handled elsewhere, so it never counts as a hazard.
  function automatic logic raw_hit(input logic [REG_AW-1:0] wa,
                                   input logic [REG_AW-1:0] ra);
    return (wa == ra) && (ra != PC_REG);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// pipe_fwd_unit: combinational forwarding-select and load-use stall logic.
// Configuration macro: PIPE_FWD_EN
//   defined   : M (ALU results only) and W results are forwarded, M first;
//               only a load in M whose result is needed raises a stall.
//   undefined : no forwarding; any RAW match against a valid M or W
//               writer raises a stall.
// Ports:
//   m_alu_wr, m_load_wr : M holds a valid register-writing ALU op / load
//   m_wa3               : destination register of the M instruction
//   w_wr, w_wa3         : W holds a valid register writer, and its target
//   ra1_e, ra2_e        : source registers of the instruction in E
//   fwd_a_e, fwd_b_e    : forwarding selects (fwd_sel_t encoding)
//   stall_load          : E/D must hold
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic              m_alu_wr,
  input  logic              m_load_wr,
  input  logic [REG_AW-1:0] m_wa3,
  input  logic              w_wr,
  input  logic [REG_AW-1:0] w_wa3,
  input  logic [REG_AW-1:0] ra1_e,
  input  logic [REG_AW-1:0] ra2_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_load
);

  logic m_wr;
  logic m_hit_a, m_hit_b, w_hit_a, w_hit_b;

  assign m_wr    = m_alu_wr | m_load_wr;
  assign m_hit_a = m_wr & raw_hit(m_wa3, ra1_e);
  assign m_hit_b = m_wr & raw_hit(m_wa3, ra2_e);
  assign w_hit_a = w_wr & raw_hit(w_wa3, ra1_e);
  assign w_hit_b = w_wr & raw_hit(w_wa3, ra2_e);

`ifdef PIPE_FWD_EN
  fwd_sel_t sel_a, sel_b;

  // A load in M has no data yet, so it can only be taken from W later.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (m_alu_wr & raw_hit(m_wa3, ra1_e)) sel_a = FWD_M;
    else if (w_hit_a)                     sel_a = FWD_W;
    if (m_alu_wr & raw_hit(m_wa3, ra2_e)) sel_b = FWD_M;
    else if (w_hit_b)                     sel_b = FWD_W;
  end

  assign fwd_a_e    = sel_a;
  assign fwd_b_e    = sel_b;
  assign stall_load = m_load_wr & (m_hit_a | m_hit_b);
`else
  assign fwd_a_e    = FWD_RF;
  assign fwd_b_e    = FWD_RF;
  assign stall_load = m_hit_a | m_hit_b | w_hit_a | w_hit_b;
`endif

endmodule

// File: rtl/pipe_mem_wb.sv
// pipe_mem_wb: Memory (M) and Writeback (W) stages of the 24-bit pipeline.
// Configuration macro: PIPE_FWD_EN (enables result forwarding; when
// undefined the forward selects/data are tied to 0 and hazards stall).
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   e_valid / e_ready          : E offers an instruction / M accepts it
//   flush                      : turn the accepted instruction into a bubble
//   alu_result_e .. ra2_e      : execute-stage results and control bits
//   mem_req/we/addr/wdata      : data-memory request, held until mem_ready
//   mem_ready, mem_rdata       : access completion and load data
//   rf_we3, rf_wa3, rf_wd3     : register-file write port
//   pc_src_w                   : branch / PC write retiring
//   fwd_a_e, fwd_b_e           : forwarding selects returned to E
//   fwd_m_data, fwd_w_data     : forwarded values
//   stall_load                 : hazard, E/D must hold
module pipe_mem_wb
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result_e,
  input  logic [DATA_W-1:0] write_data_e,
  input  logic [REG_AW-1:0] wa3_e,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic              mem_write_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] ra1_e,
  input  logic [REG_AW-1:0] ra2_e,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we3,
  output logic [REG_AW-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              pc_src_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [DATA_W-1:0] fwd_m_data,
  output logic [DATA_W-1:0] fwd_w_data,
  output logic              stall_load
);

  stage_t   m_reg, e_stage;
  m_state_t m_state_reg, m_state_next;
  logic     m_mem_op, m_done;

  logic              w_valid_reg, w_reg_write_reg, w_pc_src_reg;
  logic [REG_AW-1:0] w_wa3_reg;
  logic [DATA_W-1:0] w_wd_reg;

  assign m_mem_op = m_reg.valid & (m_reg.mem_to_reg | m_reg.mem_write);

  // Memory handshake. The first cycle of every access is spent in M_IDLE
  // raising the request, so a ready left over from a previous access can
  // never complete the next one.
  always_comb begin
    m_state_next = m_state_reg;
    m_done       = 1'b0;
    mem_req      = 1'b0;
    case (m_state_reg)
      M_IDLE: begin
        if (m_mem_op) begin
          mem_req      = 1'b1;
          m_state_next = M_WAIT;
        end else begin
          m_done = 1'b1;
        end
      end
      M_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          m_done       = 1'b1;
          m_state_next = M_IDLE;
        end
      end
      default: m_state_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_state_reg <= M_IDLE;
    else     m_state_reg <= m_state_next;
  end

  // Held low while reset is asserted so nothing is accepted during reset.
  assign e_ready = ~rst & (~m_reg.valid | m_done);

  always_comb begin
    e_stage            = STAGE_BUBBLE;
    e_stage.valid      = 1'b1;
    e_stage.alu_result = alu_result_e;
    e_stage.write_data = write_data_e;
    e_stage.wa3        = wa3_e;
    e_stage.reg_write  = reg_write_e;
    e_stage.mem_to_reg = mem_to_reg_e;
    e_stage.mem_write  = mem_write_e;
    e_stage.pc_src     = pc_src_e;
  end

  // M register: when M drains and nothing (or a flushed op) is offered,
  // it becomes a bubble; while M is busy, flush and E are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= STAGE_BUBBLE;
    end else if (e_ready) begin
      if (e_valid && !flush) m_reg <= e_stage;
      else                   m_reg <= STAGE_BUBBLE;
    end
  end

  // W register: captures a finished M instruction, otherwise a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_reg     <= 1'b0;
      w_reg_write_reg <= 1'b0;
      w_pc_src_reg    <= 1'b0;
      w_wa3_reg       <= '0;
      w_wd_reg        <= '0;
    end else if (m_reg.valid && m_done) begin
      w_valid_reg     <= 1'b1;
      w_reg_write_reg <= m_reg.reg_write;
      w_pc_src_reg    <= m_reg.pc_src;
      w_wa3_reg       <= m_reg.wa3;
      w_wd_reg        <= m_reg.mem_to_reg ? mem_rdata : m_reg.alu_result;
    end else begin
      w_valid_reg     <= 1'b0;
      w_reg_write_reg <= 1'b0;
      w_pc_src_reg    <= 1'b0;
      w_wa3_reg       <= '0;
      w_wd_reg        <= '0;
    end
  end

  // Request fields come straight from M, which cannot change until the
  // access completes, so they stay stable for the whole request.
  assign mem_we    = mem_req & m_reg.mem_write;
  assign mem_addr  = mem_req ? m_reg.alu_result : '0;
  assign mem_wdata = mem_req ? m_reg.write_data : '0;

  assign rf_we3   = w_valid_reg & w_reg_write_reg;
  assign rf_wa3   = w_wa3_reg;
  assign rf_wd3   = w_wd_reg;
  assign pc_src_w = w_valid_reg & w_pc_src_reg;

  logic m_alu_wr, m_load_wr, w_wr;
  assign m_alu_wr  = m_reg.valid & m_reg.reg_write & ~m_reg.mem_to_reg;
  assign m_load_wr = m_reg.valid & m_reg.reg_write &  m_reg.mem_to_reg;
  assign w_wr      = w_valid_reg & w_reg_write_reg;

  pipe_fwd_unit u_fwd (
    .m_alu_wr   (m_alu_wr),
    .m_load_wr  (m_load_wr),
    .m_wa3      (m_reg.wa3),
    .w_wr       (w_wr),
    .w_wa3      (w_wa3_reg),
    .ra1_e      (ra1_e),
    .ra2_e      (ra2_e),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .stall_load (stall_load)
  );

`ifdef PIPE_FWD_EN
  assign fwd_m_data = m_reg.alu_result;
  assign fwd_w_data = w_wd_reg;
`else
  assign fwd_m_data = '0;
  assign fwd_w_data = '0;
`endif

endmodule

// File: doc/pipe_mem_wb.md
Name: pipe_mem_wb

Overview:
Back half of the 24-bit pipeline. Consumes the execute-stage outputs and carries them through the Memory (M) and Writeback (W) registers. Runs the data-memory request/ready handshake and drives the register-file write port. Returns forwarding selects and a load-use stall to the execute/decode side.

Parameters:
DATA_W, 24, datapath width
REG_AW, 4, register address width
PC_REG, 15, register index never forwarded (PC alias)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
e_valid  in  1  execute stage holds a valid instruction
e_ready  out  1  M stage accepts this cycle
flush  in  1  discard the instruction offered by E this cycle
alu_result_e  in  DATA_W  ALU result / memory address
write_data_e  in  DATA_W  store data
wa3_e  in  REG_AW  destination register
reg_write_e, mem_to_reg_e, mem_write_e, pc_src_e  in  1 each  control bits from E
ra1_e, ra2_e  in  REG_AW  source registers of the instruction in E
mem_req  out  1  memory access request
mem_we  out  1  store when 1, load when 0
mem_addr  out  DATA_W  access address
mem_wdata  out  DATA_W  store data
mem_ready  in  1  access completes this cycle
mem_rdata  in  DATA_W  load data, valid with mem_ready
rf_we3  out  1  register-file write enable
rf_wa3  out  REG_AW  register-file write address
rf_wd3  out  DATA_W  register-file write data
pc_src_w  out  1  branch/PC write retiring
fwd_a_e, fwd_b_e  out  2  forwarding select: 00 = RF, 10 = M result, 01 = W result
fwd_m_data, fwd_w_data  out  DATA_W  forward values
stall_load  out  1  load-use hazard; E/D must hold

Behaviour:
- Reset: all valid bits 0, M FSM in M_IDLE, every output 0.
- Reset mid-access: mem_req drops asynchronously; the access is abandoned.
- M capture:
  - Occurs on the clk edge when e_valid & e_ready.
  - If flush is also 1, m_valid loads 0 (bubble) and the control bits are zeroed.
- e_ready = !m_valid | m_done.
  - m_done = (M_IDLE & no memory op) | (M_WAIT & mem_ready).
- M FSM:
  - M_IDLE with m_valid & (mem_to_reg_m | mem_write_m) → M_WAIT, asserting mem_req combinationally in the same cycle.
  - M_WAIT holds mem_req, mem_addr, mem_wdata and mem_we stable until mem_ready.
  - mem_ready in M_WAIT → M_IDLE. If a memory op enters M on that same edge, the FSM re-enters M_WAIT on the next cycle; mem_req is never held across instructions without a deassert check.
  - mem_ready outside M_WAIT is ignored.
- W stage:
  - On m_done, W captures the M contents; rf_wd3 = mem_to_reg ? mem_rdata (registered) : alu_result.
  - If M is not done, W loads a bubble (w_valid = 0).
- Writeback: rf_we3 = w_valid & reg_write_w; pc_src_w = w_valid & pc_src_w_reg.
- Latency: an ALU instruction with no wait states writes the RF in the 2nd cycle after E acceptance. Each memory wait cycle adds 1.
- Forwarding (per source; A shown, B identical):
  - 10 if m_valid & reg_write_m & !mem_to_reg_m & wa3_m == ra1_e & ra1_e != PC_REG.
  - Otherwise 01 if w_valid & reg_write_w & wa3_w == ra1_e & ra1_e != PC_REG.
  - Otherwise 00. M has priority over W.
- stall_load = m_valid & mem_to_reg_m & reg_write_m & (wa3_m == ra1_e | wa3_m == ra2_e), excluding PC_REG.
- Simultaneous flush with e_ready = 0: no capture occurs, and flush has no effect on M.

Optional Feature:
PIPE_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwd_a_e and fwd_b_e are tied 00; fwd_m_data and fwd_w_data are tied 0.
  - stall_load asserts on any RAW match against valid M or W writers.

Decomposition:
- Shared package pipe_pkg:
  - fwd_sel_t enum (FWD_RF = 00, FWD_W = 01, FWD_M = 10).
  - m_state_t (M_IDLE, M_WAIT).
  - Stage struct {valid, alu_result, write_data, wa3, reg_write, mem_to_reg, mem_write, pc_src}.
  - PC_REG constant.
- Sub-module pipe_fwd_unit: combinational forward-select and stall_load logic, instantiated once.

Test Plan:
- ALU op wa3 = 3, result 0x00_1234, mem_ready never asserted → rf_we3 = 1, rf_wa3 = 3, rf_wd3 = 0x001234 two cycles after acceptance.
- Load addr 0x000040, mem_ready after 3 wait cycles with rdata 0xABCDEF → mem_req held 4 cycles with addr stable; e_ready = 0 for 3 cycles; rf_wd3 = 0xABCDEF.
- Back-to-back: ALU to r5, then ALU reading r5 → fwd_a_e = 10 for one cycle, then 01 next cycle if still matching.
- Load to r2 in M while E reads r2 → stall_load = 1; with ra1_e = 15 and wa3_m = 15 → no forward, no stall.
- Flush asserted with a store accepted → no mem_req, m_valid = 0, next instruction unaffected.
- rst asserted during M_WAIT → mem_req = 0 immediately; after release, FSM is M_IDLE and rf_we3 = 0.
